// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// A grant lasts for one packet or MAX_BURST beats, and is released early if the holder drops valid.
module fifo_write_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 16,
  localparam int unsigned IdW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int unsigned CntW      = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          grant_valid,
  output logic [IdW-1:0]                grant_id,
  output logic [CntW-1:0]               beat_count
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IdW-1:0]  grant_id_q, grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic [CntW-1:0] beat_count_q, beat_count_d;
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;

  logic [IdW-1:0]        pick_id;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  xfer;

  // First requesting index strictly after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic        found;
    idx     = 0;
    found   = 1'b0;
    pick_id = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        pick_id = IdW'(idx);
      end
    end
  end

  always_comb begin
    sel_valid = req_valid[grant_id_q];
    sel_last  = req_last[grant_id_q];
    sel_data  = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    beat_count_d  = beat_count_q;
    rr_ptr_d      = rr_ptr_q;
    req_ready     = '0;
    fifo_write_en = 1'b0;
    fifo_data     = '0;
    xfer          = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|req_valid) begin
          state_d       = StGrant;
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          beat_count_d  = '0;
        end
      end
      StGrant: begin
        req_ready[grant_id_q] = !fifo_full;
        xfer = sel_valid && !fifo_full;
        if (xfer) begin
          fifo_write_en = 1'b1;
          fifo_data     = sel_data;
          beat_count_d  = beat_count_q + CntW'(1);
        end
        // beat_count is left at its final value while idle; it clears on the next grant.
        if ((xfer && (sel_last || beat_count_q == CntW'(MAX_BURST - 1))) || !sel_valid) begin
          state_d       = StIdle;
          grant_valid_d = 1'b0;
          rr_ptr_d      = grant_id_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      beat_count_q  <= '0;
      rr_ptr_q      <= IdW'(NUM_REQ - 1);
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      beat_count_q  <= beat_count_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign beat_count  = beat_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: queued producers and a 64-deep FIFO occupancy model.
module tb_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_write_en;
  logic [7:0]  fifo_data;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic [4:0]  beat_count;

  fifo_write_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(8),
    .MAX_BURST (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_write_en(fifo_write_en),
    .fifo_data    (fifo_data),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .beat_count   (beat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int cyc    = 0;
  int fcount = 0;
  int rd_pending = 0;
  logic force_full = 1'b0;

  logic [8:0]  pq [4][$];  // {last, data} per producer
  logic [15:0] wlog [$];   // {id, data} per accepted write
  int          wcyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < 4; i++) begin
      if (pq[i].size() > 0) begin
        e = pq[i][0];
        req_valid[i]       = 1'b1;
        req_data[i*8 +: 8] = e[7:0];
        req_last[i]        = e[8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[i*8 +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    fifo_full = force_full || (fcount >= 64);
    #1;
  endtask

  // Sample at the falling edge, advance past the rising edge, then update producers and FIFO.
  task automatic cycle();
    logic [3:0] xf;
    @(negedge clk);
    xf = req_valid & req_ready;
    if (fifo_write_en) begin
      if (fifo_full) viol++;
      wlog.push_back({6'b0, grant_id, fifo_data});
      wcyc.push_back(cyc);
      fcount++;
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < 4; i++)
      if (xf[i] && pq[i].size() > 0) void'(pq[i].pop_front());
    if (rd_pending > 0 && fcount > 0) begin
      fcount--;
      rd_pending--;
    end
    drive();
  endtask

  task automatic clear_logs();
    wlog.delete();
    wcyc.delete();
    fcount = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] e;
    int bad;
    int cnt [4];
    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    chk("rst_bc", beat_count, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_we", fifo_write_en, 0);
    chk("rst_data", fifo_data, 0);
    reset = 1'b0;
    drive();

    // Fairness: three 1-beat packets from each producer.
    clear_logs();
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 3; k++) pq[i].push_back({1'b1, 8'(8'h10 + i)});
    drive();
    for (int k = 0; k < 80 && wlog.size() < 12; k++) cycle();
    chk("fair_count", wlog.size(), 12);
    bad = 0;
    for (int k = 0; k < wlog.size() && k < 12; k++) begin
      e = wlog[k];
      chk("fair_id", e[9:8], k % 4);
      chk("fair_data", e[7:0], 8'h10 + k % 4);
      if (k > 0 && wcyc[k] - wcyc[k-1] != 2) bad++;
    end
    chk("fair_bubble", bad, 0);
    cycle();

    // Single 3-beat packet from producer 2.
    clear_logs();
    pq[2].push_back({1'b0, 8'hA1});
    pq[2].push_back({1'b0, 8'hA2});
    pq[2].push_back({1'b1, 8'hA3});
    drive();
    chk("sp_idle_gv", grant_valid, 0);
    chk("sp_idle_we", fifo_write_en, 0);
    cycle();
    chk("sp_gv", grant_valid, 1);
    chk("sp_gid", grant_id, 2);
    chk("sp_bc0", beat_count, 0);
    chk("sp_ready", req_ready, 4'b0100);
    chk("sp_we", fifo_write_en, 1);
    chk("sp_d1", fifo_data, 8'hA1);
    cycle();
    chk("sp_bc1", beat_count, 1);
    chk("sp_d2", fifo_data, 8'hA2);
    cycle();
    chk("sp_bc2", beat_count, 2);
    chk("sp_d3", fifo_data, 8'hA3);
    cycle();
    chk("sp_bc3", beat_count, 3);
    chk("sp_rel_gv", grant_valid, 0);
    chk("sp_rel_we", fifo_write_en, 0);
    chk("sp_rel_data", fifo_data, 0);
    chk("sp_rel_ready", req_ready, 0);
    chk("sp_log_n", wlog.size(), 3);
    e = wlog[2];
    chk("sp_log_last", e, {6'b0, 2'd2, 8'hA3});

    // Burst cap: 20 beats from producer 1, producer 3 joins after the grant.
    clear_logs();
    for (int k = 0; k < 20; k++) pq[1].push_back({1'b0, 8'(8'h20 + k)});
    drive();
    cycle();
    chk("bu_gid", grant_id, 1);
    pq[3].push_back({1'b1, 8'h33});
    drive();
    for (int k = 0; k < 120 && wlog.size() < 21; k++) cycle();
    chk("bu_count", wlog.size(), 21);
    bad = 0;
    for (int k = 0; k < wlog.size() && k < 21; k++) begin
      if (k < 16) begin
        if (wlog[k] !== {6'b0, 2'd1, 8'(8'h20 + k)}) bad++;
      end else if (k == 16) begin
        if (wlog[k] !== {6'b0, 2'd3, 8'h33}) bad++;
      end else begin
        if (wlog[k] !== {6'b0, 2'd1, 8'(8'h20 + k - 1)}) bad++;
      end
    end
    chk("bu_order", bad, 0);
    chk("bu_drained", pq[1].size(), 0);
    repeat (2) cycle();

    // Reset asserted in the middle of a grant.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      pq[i].push_back({1'b0, 8'(8'h40 + i)});
      pq[i].push_back({1'b1, 8'(8'h48 + i)});
    end
    drive();
    cycle();
    cycle();
    chk("mr_pre_gid", grant_id, 2);
    chk("mr_pre_bc", beat_count, 1);
    reset = 1'b1;
    #1;
    chk("mr_gv", grant_valid, 0);
    chk("mr_gid", grant_id, 0);
    chk("mr_bc", beat_count, 0);
    chk("mr_ready", req_ready, 0);
    chk("mr_we", fifo_write_en, 0);
    chk("mr_data", fifo_data, 0);
    cycle();
    reset = 1'b0;
    drive();
    cycle();
    chk("mr_post_gv", grant_valid, 1);
    chk("mr_post_gid", grant_id, 0);
    for (int i = 0; i < 4; i++) pq[i].delete();
    drive();
    repeat (3) cycle();
    chk("mr_idle", grant_valid, 0);

    // Backpressure mid-burst.
    clear_logs();
    for (int k = 0; k < 8; k++) pq[0].push_back({k == 7, 8'(8'h50 + k)});
    drive();
    cycle();
    repeat (3) cycle();
    chk("bp_bc_pre", beat_count, 3);
    chk("bp_n_pre", wlog.size(), 3);
    force_full = 1'b1;
    drive();
    for (int j = 0; j < 3; j++) begin
      chk("bp_ready", req_ready, 0);
      chk("bp_we", fifo_write_en, 0);
      chk("bp_data", fifo_data, 0);
      chk("bp_bc", beat_count, 3);
      chk("bp_gid", grant_id, 0);
      chk("bp_gv", grant_valid, 1);
      cycle();
    end
    force_full = 1'b0;
    drive();
    chk("bp_resume_we", fifo_write_en, 1);
    chk("bp_resume_data", fifo_data, 8'h53);
    for (int k = 0; k < 40 && wlog.size() < 8; k++) cycle();
    chk("bp_count", wlog.size(), 8);
    bad = 0;
    for (int k = 0; k < wlog.size(); k++)
      if (wlog[k] !== {6'b0, 2'd0, 8'(8'h50 + k)}) bad++;
    chk("bp_order", bad, 0);
    repeat (2) cycle();

    // Fill the 64-deep FIFO with 70 beats, then release 6 reads.
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      int n;
      n = (i < 2) ? 18 : 17;
      for (int k = 0; k < n; k++) pq[i].push_back({k == n - 1, 8'(i * 32 + k)});
    end
    drive();
    for (int k = 0; k < 400 && wlog.size() < 64; k++) cycle();
    repeat (5) cycle();
    chk("ff_count64", wlog.size(), 64);
    chk("ff_full", fifo_full, 1);
    chk("ff_stall_we", fifo_write_en, 0);
    chk("ff_stall_ready", req_ready, 0);
    chk("ff_stall_gv", grant_valid, 1);
    rd_pending = 6;
    for (int k = 0; k < 200 && wlog.size() < 70; k++) cycle();
    repeat (5) cycle();
    chk("ff_count70", wlog.size(), 70);
    chk("ff_full_again", fifo_full, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    for (int k = 0; k < wlog.size(); k++) begin
      e = wlog[k];
      if (e[7:0] !== 8'(e[9:8] * 32 + cnt[e[9:8]])) bad++;
      cnt[e[9:8]]++;
    end
    chk("ff_order", bad, 0);
    chk("ff_n0", cnt[0], 18);
    chk("ff_n1", cnt[1], 18);
    chk("ff_n2", cnt[2], 17);
    chk("ff_n3", cnt[3], 17);
    chk("no_write_when_full", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
